tt_um_ks_operand_sequencer: RTL and testbench

TT_UM_KS_OPERAND_SEQUENCER -- requirements
Module: tt_um_ks_operand_sequencer

---
 rtl/tt_um_ks_operand_sequencer_if.sv | 23 ++
 rtl/tt_um_ks_operand_sequencer.sv | 135 +++++++++++++
 tb/tb_tt_um_ks_operand_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_ks_operand_sequencer_if.sv
// Operand/result handshake bundle between the pin wrapper and the sequencer core.
interface tt_um_ks_operand_sequencer_if;
    logic [7:0] operand;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       acc_mode;
    logic       clear;
    logic [7:0] sum;
    logic       out_valid;
    logic       carry_out;
    logic       timeout_flag;

    modport master (
        output operand, in_valid, out_ready, acc_mode, clear,
        input  in_ready, sum, out_valid, carry_out, timeout_flag
    );

    modport slave (
        input  operand, in_valid, out_ready, acc_mode, clear,
        output in_ready, sum, out_valid, carry_out, timeout_flag
    );
endinterface

// File: rtl/tt_um_ks_operand_sequencer.sv
// Two-operand / accumulate adder sequencer with a valid/ready handshake, WAIT_B
// timeout and sticky timeout flag, wrapped onto the Tiny Tapeout pin set.
module tt_um_ks_operand_sequencer_core #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input logic clk,
    input logic rst_n,
    tt_um_ks_operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_B, RESULT} state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] sum_q, sum_d;
    logic       carry_q, carry_d;
    logic       flag_q, flag_d;
    logic [7:0] count_q, count_d;
    logic [7:0] add_a;
    logic [8:0] add_res;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        flag_d  = flag_q;
        count_d = count_q;
        add_a   = (state_q == IDLE) ? acc_q : a_q;
        add_res = {1'b0, add_a} + {1'b0, bus.operand};

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = 8'd0;
            flag_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.acc_mode) begin
                            {carry_d, sum_d} = add_res;
                            acc_d            = add_res[7:0];
                            state_d          = RESULT;
                        end else begin
                            a_d     = bus.operand;
                            count_d = 8'd0;
                            state_d = WAIT_B;
                        end
                    end
                end
                WAIT_B: begin
                    // A late B beat still wins over the timeout in the same cycle.
                    if (bus.in_valid) begin
                        {carry_d, sum_d} = add_res;
                        acc_d            = add_res[7:0];
                        state_d          = RESULT;
                    end else if (count_q == TIMEOUT - 8'd1) begin
                        a_d     = 8'd0;
                        flag_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                RESULT: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            acc_q   <= 8'd0;
            sum_q   <= 8'd0;
            carry_q <= 1'b0;
            flag_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready     = (state_q != RESULT);
    assign bus.out_valid    = (state_q == RESULT);
    assign bus.sum          = sum_q;
    assign bus.carry_out    = carry_q;
    assign bus.timeout_flag = flag_q;
endmodule

module tt_um_ks_operand_sequencer #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    tt_um_ks_operand_sequencer_if bus ();

    logic unused_pins;
    assign unused_pins = &{ena, uio_in[7:4]};

    assign bus.operand   = ui_in;
    assign bus.in_valid  = uio_in[0];
    assign bus.out_ready = uio_in[1];
    assign bus.acc_mode  = uio_in[2];
    assign bus.clear     = uio_in[3];

    tt_um_ks_operand_sequencer_core #(.TIMEOUT(TIMEOUT)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign uo_out  = bus.sum;
    assign uio_out = {bus.timeout_flag, bus.carry_out, bus.out_valid, bus.in_ready, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_ks_operand_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_tt_um_ks_operand_sequencer;
    localparam logic [7:0] TO = 8'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_um_ks_operand_sequencer_if tb_bus ();

    assign ui_in  = tb_bus.operand;
    assign uio_in = {4'b0000, tb_bus.clear, tb_bus.acc_mode, tb_bus.out_ready, tb_bus.in_valid};
    assign tb_bus.sum          = uo_out;
    assign tb_bus.in_ready     = uio_out[4];
    assign tb_bus.out_valid    = uio_out[5];
    assign tb_bus.carry_out    = uio_out[6];
    assign tb_bus.timeout_flag = uio_out[7];

    tt_um_ks_operand_sequencer #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue holding the pending A operand, a "result held" bit.
    logic [7:0] pend[$];
    bit         m_res;
    int         m_wait;
    logic [7:0] m_acc, m_sum;
    bit         m_carry, m_flag;
    bit         model_on = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_result(input logic [7:0] a, input logic [7:0] b);
        int s;
        s       = int'(a) + int'(b);
        m_sum   = 8'(s % 256);
        m_carry = (s >= 256);
        m_acc   = m_sum;
        m_res   = 1'b1;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            pend.delete();
            m_res = 0; m_wait = 0; m_acc = 0; m_sum = 0; m_carry = 0; m_flag = 0;
        end else if (tb_bus.clear) begin
            pend.delete();
            m_res = 0; m_acc = 0; m_flag = 0;
        end else if (m_res) begin
            if (tb_bus.out_ready) m_res = 0;
        end else if (pend.size() == 0) begin
            if (tb_bus.in_valid) begin
                if (tb_bus.acc_mode) add_result(m_acc, tb_bus.operand);
                else begin
                    pend.push_back(tb_bus.operand);
                    m_wait = 0;
                end
            end
        end else begin
            if (tb_bus.in_valid) begin
                add_result(pend[0], tb_bus.operand);
                pend.delete();
            end else if (m_wait == int'(TO) - 1) begin
                pend.delete();
                m_flag = 1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic step(input logic [7:0] d, input bit v, input bit r, input bit am, input bit cl);
        tb_bus.operand   = d;
        tb_bus.in_valid  = v;
        tb_bus.out_ready = r;
        tb_bus.acc_mode  = am;
        tb_bus.clear     = cl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("uo_out_model", uo_out, m_sum);
            check("uio_out_model", uio_out, {m_flag, m_carry, m_res, ~m_res, 4'b0000});
            check("uio_oe_model", uio_oe, 8'hF0);
        end
    end

    initial begin
        rst_n = 1'b0;
        step(8'h00, 0, 0, 0, 0);
        model_on = 1'b1;
        step(8'h00, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(8'h00, 0, 0, 0, 0);
        check("post_reset_status", uio_out, 8'h10);
        check("post_reset_sum", uo_out, 8'h00);

        // Plain pair 3C + 05.
        step(8'h3C, 1, 1, 0, 0);
        step(8'h05, 1, 1, 0, 0);
        check("pair_sum", uo_out, 8'h41);
        check("pair_status", uio_out, 8'h20);
        step(8'h00, 0, 1, 0, 0);
        check("pair_handoff_status", uio_out, 8'h10);
        check("pair_handoff_hold", uo_out, 8'h41);

        // Wrap with carry, then accumulate.
        step(8'hFF, 1, 1, 0, 0);
        step(8'h02, 1, 1, 0, 0);
        check("wrap_sum", uo_out, 8'h01);
        check("wrap_status", uio_out, 8'h60);
        step(8'h00, 0, 1, 0, 0);
        step(8'h10, 1, 1, 1, 0);
        check("acc_sum", uo_out, 8'h11);
        check("acc_status", uio_out, 8'h20);
        step(8'h00, 0, 1, 0, 0);

        // Back-pressure: result held while out_ready stays low.
        step(8'h20, 1, 0, 0, 0);
        step(8'h30, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(8'(8'hA0 + i), 1'(i % 2), 0, 0, 0);
            check("stall_sum", uo_out, 8'h50);
            check("stall_status", uio_out, 8'h20);
        end
        step(8'h00, 0, 1, 0, 0);
        check("stall_release", uio_out, 8'h10);

        // Timeout after exactly TO WAIT_B cycles.
        step(8'hAA, 1, 0, 0, 0);
        for (int i = 0; i < int'(TO) - 1; i++) begin
            step(8'h00, 0, 0, 0, 0);
            check("waiting_status", uio_out, 8'h10);
        end
        step(8'h00, 0, 0, 0, 0);
        check("timeout_flag_set", uio_out, 8'h90);
        step(8'h01, 1, 0, 0, 0);
        check("after_timeout_new_a", uio_out, 8'h90);
        step(8'h02, 1, 0, 0, 0);
        check("after_timeout_sum", uo_out, 8'h03);
        check("sticky_flag", uio_out, 8'hA0);
        step(8'h00, 0, 1, 0, 0);
        step(8'h00, 0, 0, 0, 1);
        check("clear_flag", uio_out, 8'h10);
        check("clear_keeps_sum", uo_out, 8'h03);

        // B on the last allowed WAIT_B cycle beats the timeout.
        step(8'h10, 1, 0, 0, 0);
        for (int i = 0; i < int'(TO) - 1; i++) step(8'h00, 0, 0, 0, 0);
        step(8'h07, 1, 0, 0, 0);
        check("late_b_sum", uo_out, 8'h17);
        check("late_b_status", uio_out, 8'h20);
        step(8'h00, 0, 1, 0, 0);

        // Clear wins over a B beat in WAIT_B.
        step(8'h44, 1, 0, 0, 0);
        step(8'h55, 1, 0, 0, 1);
        check("clear_vs_beat_status", uio_out, 8'h10);
        check("clear_vs_beat_sum", uo_out, 8'h17);
        step(8'h09, 1, 0, 1, 0);
        check("acc_zeroed", uo_out, 8'h09);
        step(8'h00, 0, 1, 0, 0);

        // Reset while a result is held.
        step(8'h3C, 1, 0, 0, 0);
        step(8'h05, 1, 0, 0, 0);
        check("pre_reset_sum", uo_out, 8'h41);
        rst_n = 1'b0;
        step(8'h00, 0, 1, 0, 1);
        check("reset_sum", uo_out, 8'h00);
        check("reset_status", uio_out, 8'h10);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(99) != 0);
            step(8'($urandom), 1'($urandom_range(1)), ($urandom_range(9) < 3),
                 ($urandom_range(3) == 0), ($urandom_range(49) == 0));
        end
        rst_n = 1'b1;
        step(8'h00, 0, 1, 0, 0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
